// File: rtl/uart_command_parser_pkg.sv
// ---------------------------------------------------------------------------
// uart_command_parser_pkg
//   Shared definitions for the UART line-command parser:
//     - ASCII constants used by the parser and the response ROM
//     - parser FSM state encoding
//     - response identifiers selecting the reply string
//     - small helper for case-insensitive command letter matching
// ---------------------------------------------------------------------------
package uart_command_parser_pkg;

    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_C_UP  = 8'h43;
    localparam logic [7:0] ASCII_C_LO  = 8'h63;
    localparam logic [7:0] ASCII_QMARK = 8'h3F;
    localparam logic [7:0] ASCII_0     = 8'h30;
    localparam logic [7:0] ASCII_1     = 8'h31;
    localparam logic [7:0] ASCII_O     = 8'h4F;
    localparam logic [7:0] ASCII_K     = 8'h4B;
    localparam logic [7:0] ASCII_E     = 8'h45;
    localparam logic [7:0] ASCII_R     = 8'h52;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RX_ACK    = 3'd1,
        ST_ECHO_SEND = 3'd2,
        ST_ECHO_WAIT = 3'd3,
        ST_EXEC      = 3'd4,
        ST_RESP_SEND = 3'd5,
        ST_RESP_WAIT = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        RESP_OK  = 2'd0,
        RESP_QRY = 2'd1,
        RESP_ERR = 2'd2
    } resp_id_t;

    // Command letters are accepted in either case.
    function automatic logic is_chan_letter(input logic [7:0] b);
        return (b == ASCII_C_UP) || (b == ASCII_C_LO);
    endfunction

endpackage

// File: rtl/uart_response_rom.sv
// ---------------------------------------------------------------------------
// uart_response_rom
//   Combinational lookup of the 4-byte reply strings sent after a command.
//     OK  -> "OK\r\n"
//     QRY -> 'C', '1'+Channel_In, "\r\n"
//     ERR -> "ER\r\n"
// Ports
//   Resp_ID    in  2  reply selector (resp_id_t encoding)
//   Index      in  2  byte position within the reply, 0..3
//   Channel_In in  4  0-based channel reported by the query reply
//   Byte       out 8  ASCII byte at that position
// ---------------------------------------------------------------------------
module uart_response_rom
    import uart_command_parser_pkg::*;
(
    input  logic [1:0] Resp_ID,
    input  logic [1:0] Index,
    input  logic [3:0] Channel_In,
    output logic [7:0] Byte
);

    always_comb begin
        Byte = 8'h00;
        case (Index)
            2'd0: begin
                case (Resp_ID)
                    RESP_OK:  Byte = ASCII_O;
                    RESP_QRY: Byte = ASCII_C_UP;
                    RESP_ERR: Byte = ASCII_E;
                    default:  Byte = 8'h00;
                endcase
            end
            2'd1: begin
                case (Resp_ID)
                    RESP_OK:  Byte = ASCII_K;
                    RESP_QRY: Byte = ASCII_1 + {4'h0, Channel_In};
                    RESP_ERR: Byte = ASCII_R;
                    default:  Byte = 8'h00;
                endcase
            end
            2'd2:    Byte = ASCII_CR;
            default: Byte = ASCII_LF;
        endcase
    end

endmodule

// File: rtl/uart_command_parser.sv
// ---------------------------------------------------------------------------
// uart_command_parser
//   Line-based ASCII command parser sitting between the UART Rx/Tx handshakes
//   and the channel control. Echoes typed bytes, buffers a line, and on CR
//   decodes it and sends a 4-byte reply:
//     "C<d>" (d = '1'..NUM_CHANNELS, C either case) -> load channel d-1, "OK"
//     "?"                                         -> "C<current channel+1>"
//     anything else or an over-long line          -> "ER"
//   An empty line produces no reply.
// Ports
//   Clk_1_410_590 in   1  system clock
//   Reset         in   1  synchronous, active-high
//   Rx_Data       in   8  received byte, valid while Rx_Ready=1
//   Rx_Ready      in   1  held by the UART until Rx_Ack is seen
//   Rx_Ack        out  1  level acknowledge, held until Rx_Ready falls
//   Tx_Data       out  8  byte to transmit, stable while Tx_Send=1
//   Tx_Send       out  1  held until Tx_Busy rises
//   Tx_Busy       in   1  UART transmitter busy
//   Channel_In    in   4  current 0-based channel, for the query reply
//   Channel_Out   out  4  requested 0-based channel
//   Channel_Load  out  1  one-cycle pulse qualifying Channel_Out
// ---------------------------------------------------------------------------
module uart_command_parser
    import uart_command_parser_pkg::*;
#(
    parameter int NUM_CHANNELS = 6,
    parameter int MAX_LEN      = 4,
    parameter int ECHO         = 1
) (
    input  logic       Clk_1_410_590,
    input  logic       Reset,
    input  logic [7:0] Rx_Data,
    input  logic       Rx_Ready,
    output logic       Rx_Ack,
    output logic [7:0] Tx_Data,
    output logic       Tx_Send,
    input  logic       Tx_Busy,
    input  logic [3:0] Channel_In,
    output logic [3:0] Channel_Out,
    output logic       Channel_Load
);

    localparam int               CNT_W      = $clog2(MAX_LEN + 1);
    localparam int               IDX_W      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [CNT_W-1:0] MAX_CNT    = CNT_W'(MAX_LEN);
    localparam logic [7:0]       LAST_DIGIT = 8'(ASCII_0 + NUM_CHANNELS);
    localparam bit               ECHO_EN    = (ECHO != 0);

    state_t           state;
    logic [7:0]       rx_byte;
    logic [7:0]       line_buf [MAX_LEN];
    logic [CNT_W-1:0] count;
    logic             overflow;
    resp_id_t         resp_id;
    logic [1:0]       resp_idx;
    logic [3:0]       chan_q;
    logic [7:0]       rom_byte;

    logic             line_empty;
    logic             cmd_chan;
    logic             cmd_query;

    uart_response_rom u_rom (
        .Resp_ID    (resp_id),
        .Index      (resp_idx),
        .Channel_In (chan_q),
        .Byte       (rom_byte)
    );

    // Line decode, consumed in EXEC. An overflowed line never matches a command.
    assign line_empty = !overflow && (count == '0);
    assign cmd_chan   = !overflow && (count == CNT_W'(2)) &&
                        is_chan_letter(line_buf[0]) &&
                        (line_buf[1] >= ASCII_1) && (line_buf[1] <= LAST_DIGIT);
    assign cmd_query  = !overflow && (count == CNT_W'(1)) &&
                        (line_buf[0] == ASCII_QMARK);

    always_ff @(posedge Clk_1_410_590) begin
        if (Reset) begin
            state        <= ST_IDLE;
            Rx_Ack       <= 1'b0;
            Tx_Data      <= 8'h00;
            Tx_Send      <= 1'b0;
            Channel_Out  <= 4'h0;
            Channel_Load <= 1'b0;
            count        <= '0;
            overflow     <= 1'b0;
            resp_id      <= RESP_OK;
            resp_idx     <= 2'd0;
            for (int i = 0; i < MAX_LEN; i++) line_buf[i] <= 8'h00;
        end else begin
            Channel_Load <= 1'b0;

            case (state)
                ST_IDLE: begin
                    // Only place Rx_Ack can rise: the UART is held off while busy.
                    if (Rx_Ready) begin
                        rx_byte <= Rx_Data;
                        Rx_Ack  <= 1'b1;
                        state   <= ST_RX_ACK;
                    end
                end

                ST_RX_ACK: begin
                    if (!Rx_Ready) begin
                        Rx_Ack <= 1'b0;
                        if (rx_byte != ASCII_LF && rx_byte != ASCII_CR) begin
                            if (count < MAX_CNT) begin
                                line_buf[count[IDX_W-1:0]] <= rx_byte;
                                count <= count + 1'b1;
                            end else begin
                                overflow <= 1'b1;
                            end
                        end
                        if (ECHO_EN && rx_byte != ASCII_LF) begin
                            state <= ST_ECHO_SEND;
                            // Start the echo on this same edge when the transmitter is free.
                            if (!Tx_Busy) begin
                                Tx_Data <= rx_byte;
                                Tx_Send <= 1'b1;
                            end
                        end else if (rx_byte == ASCII_CR) begin
                            state <= ST_EXEC;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end

                ST_ECHO_SEND: begin
                    if (Tx_Send) begin
                        if (Tx_Busy) begin
                            Tx_Send <= 1'b0;
                            state   <= ST_ECHO_WAIT;
                        end
                    end else if (!Tx_Busy) begin
                        Tx_Data <= rx_byte;
                        Tx_Send <= 1'b1;
                    end
                end

                ST_ECHO_WAIT: begin
                    if (!Tx_Busy) begin
                        state <= (rx_byte == ASCII_CR) ? ST_EXEC : ST_IDLE;
                    end
                end

                ST_EXEC: begin
                    chan_q   <= Channel_In;
                    resp_idx <= 2'd0;
                    count    <= '0;
                    overflow <= 1'b0;
                    for (int i = 0; i < MAX_LEN; i++) line_buf[i] <= 8'h00;
                    if (line_empty) begin
                        state <= ST_IDLE;
                    end else begin
                        state <= ST_RESP_SEND;
                        if (cmd_chan) begin
                            // Low nibble of '1'..'9' is the digit value itself.
                            Channel_Out  <= line_buf[1][3:0] - 4'd1;
                            Channel_Load <= 1'b1;
                            resp_id      <= RESP_OK;
                        end else if (cmd_query) begin
                            resp_id <= RESP_QRY;
                        end else begin
                            resp_id <= RESP_ERR;
                        end
                    end
                end

                ST_RESP_SEND: begin
                    if (Tx_Send) begin
                        if (Tx_Busy) begin
                            Tx_Send <= 1'b0;
                            state   <= ST_RESP_WAIT;
                        end
                    end else if (!Tx_Busy) begin
                        Tx_Data <= rom_byte;
                        Tx_Send <= 1'b1;
                    end
                end

                ST_RESP_WAIT: begin
                    if (!Tx_Busy) begin
                        if (resp_idx == 2'd3) begin
                            state <= ST_IDLE;
                        end else begin
                            resp_idx <= resp_idx + 2'd1;
                            state    <= ST_RESP_SEND;
                        end
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_command_parser.sv
// ---------------------------------------------------------------------------
// tb_uart_command_parser
//   Self-checking bench for uart_command_parser (default parameters).
//   UART model: 4-phase Rx handshake; Tx_Busy rises two cycles after Tx_Send
//   is seen and stays high for 20 cycles. Expected Tx bytes and channel loads
//   are queued as stimulus is driven and compared against what the DUT emits.
// ---------------------------------------------------------------------------
module tb_uart_command_parser;

    logic       Clk_1_410_590 = 1'b0;
    logic       Reset;
    logic [7:0] Rx_Data;
    logic       Rx_Ready;
    logic       Rx_Ack;
    logic [7:0] Tx_Data;
    logic       Tx_Send;
    logic       Tx_Busy;
    logic [3:0] Channel_In;
    logic [3:0] Channel_Out;
    logic       Channel_Load;

    int checks = 0;
    int errors = 0;
    int proto_err = 0;

    logic [7:0] exp_q[$];
    logic [7:0] obs_q[$];
    logic [3:0] exp_load_q[$];
    logic [3:0] obs_load_q[$];

    logic       prev_send = 1'b0;
    logic [7:0] prev_data = 8'h00;

    always #5 Clk_1_410_590 = ~Clk_1_410_590;

    uart_command_parser dut (
        .Clk_1_410_590 (Clk_1_410_590),
        .Reset         (Reset),
        .Rx_Data       (Rx_Data),
        .Rx_Ready      (Rx_Ready),
        .Rx_Ack        (Rx_Ack),
        .Tx_Data       (Tx_Data),
        .Tx_Send       (Tx_Send),
        .Tx_Busy       (Tx_Busy),
        .Channel_In    (Channel_In),
        .Channel_Out   (Channel_Out),
        .Channel_Load  (Channel_Load)
    );

    // UART transmitter model: records each byte and drives Tx_Busy.
    initial begin
        Tx_Busy = 1'b0;
        forever begin
            @(negedge Clk_1_410_590);
            if (Tx_Send === 1'b1 && Tx_Busy === 1'b0) begin
                obs_q.push_back(Tx_Data);
                repeat (2) @(negedge Clk_1_410_590);
                Tx_Busy = 1'b1;
                repeat (20) @(negedge Clk_1_410_590);
                Tx_Busy = 1'b0;
            end
        end
    end

    // Handshake rule watcher and channel-load capture.
    always @(posedge Clk_1_410_590) begin
        #1;
        if (Tx_Send === 1'b1 && prev_send === 1'b0 && Tx_Busy === 1'b1)
            proto_err <= proto_err + 1;
        if (Tx_Send === 1'b1 && prev_send === 1'b1 && Tx_Data !== prev_data)
            proto_err <= proto_err + 1;
        if (Channel_Load === 1'b1)
            obs_load_q.push_back(Channel_Out);
        prev_send <= Tx_Send;
        prev_data <= Tx_Data;
    end

    task automatic send_byte(input logic [7:0] b);
        int n;
        @(negedge Clk_1_410_590);
        Rx_Data  = b;
        Rx_Ready = 1'b1;
        n = 0;
        while (Rx_Ack !== 1'b1 && n < 1000) begin
            @(negedge Clk_1_410_590);
            n++;
        end
        if (Rx_Ack !== 1'b1) begin
            checks++; errors++;
            $display("FAIL rx_ack_rise byte=%h got ack=%b want 1", b, Rx_Ack);
        end
        Rx_Ready = 1'b0;
        n = 0;
        while (Rx_Ack !== 1'b0 && n < 100) begin
            @(negedge Clk_1_410_590);
            n++;
        end
        if (Rx_Ack !== 1'b0) begin
            checks++; errors++;
            $display("FAIL rx_ack_fall byte=%h got ack=%b want 0", b, Rx_Ack);
        end
        if (b != 8'h0A) exp_q.push_back(b);
    endtask

    task automatic push_resp(input logic [7:0] b0, input logic [7:0] b1);
        exp_q.push_back(b0);
        exp_q.push_back(b1);
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!(obs_q.size() >= exp_q.size() && Tx_Busy === 1'b0 && Tx_Send === 1'b0)
               && n < 3000) begin
            @(negedge Clk_1_410_590);
            n++;
        end
        if (n >= 3000) begin
            checks++; errors++;
            $display("FAIL tx_drain_timeout got %0d bytes want %0d", obs_q.size(), exp_q.size());
        end
        repeat (30) @(negedge Clk_1_410_590);
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        Rx_Ready = 1'b0;
        Rx_Data = 8'h00;
        Channel_In = 4'h0;
        repeat (3) @(negedge Clk_1_410_590);
        checks++; if (Rx_Ack !== 1'b0) begin errors++; $display("FAIL reset_rx_ack got %b want 0", Rx_Ack); end
        checks++; if (Tx_Send !== 1'b0) begin errors++; $display("FAIL reset_tx_send got %b want 0", Tx_Send); end
        checks++; if (Tx_Data !== 8'h00) begin errors++; $display("FAIL reset_tx_data got %h want 00", Tx_Data); end
        checks++; if (Channel_Out !== 4'h0) begin errors++; $display("FAIL reset_chan_out got %h want 0", Channel_Out); end
        checks++; if (Channel_Load !== 1'b0) begin errors++; $display("FAIL reset_chan_load got %b want 0", Channel_Load); end
        Reset = 1'b0;
        repeat (2) @(negedge Clk_1_410_590);
        obs_load_q.delete();
    endtask

    task automatic test_channel_select();
        logic [7:0] e, o;
        Channel_In = 4'h0;
        send_byte(8'h43); send_byte(8'h33); send_byte(8'h0D);
        push_resp(8'h4F, 8'h4B);
        exp_load_q.push_back(4'h2);
        wait_idle();
        checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL t1_tx_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; if (o !== e) begin errors++; $display("FAIL t1_tx_byte got %h want %h", o, e); end
        end
        checks++; if (obs_load_q.size() !== exp_load_q.size()) begin errors++; $display("FAIL t1_load_count got %0d want %0d", obs_load_q.size(), exp_load_q.size()); end
        while (exp_load_q.size() > 0 && obs_load_q.size() > 0) begin
            checks++; o = {4'h0, obs_load_q.pop_front()}; e = {4'h0, exp_load_q.pop_front()};
            if (o !== e) begin errors++; $display("FAIL t1_load_value got %h want %h", o, e); end
        end
        checks++; if (Channel_Out !== 4'h2) begin errors++; $display("FAIL t1_chan_hold got %h want 2", Channel_Out); end
        exp_q.delete(); obs_q.delete(); exp_load_q.delete(); obs_load_q.delete();
    endtask

    task automatic test_query();
        logic [7:0] e, o;
        Channel_In = 4'h5;
        send_byte(8'h3F); send_byte(8'h0D);
        push_resp(8'h43, 8'h36);
        wait_idle();
        checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL t2_tx_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; if (o !== e) begin errors++; $display("FAIL t2_tx_byte got %h want %h", o, e); end
        end
        checks++; if (obs_load_q.size() !== 0) begin errors++; $display("FAIL t2_no_load got %0d loads want 0", obs_load_q.size()); end
        checks++; if (Channel_Out !== 4'h2) begin errors++; $display("FAIL t2_chan_hold got %h want 2", Channel_Out); end
        exp_q.delete(); obs_q.delete(); obs_load_q.delete();
    endtask

    task automatic test_errors();
        logic [7:0] e, o;
        logic [7:0] line3 [7];
        line3 = '{8'h43, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h0D};
        send_byte(8'h43); send_byte(8'h37); send_byte(8'h0D);
        push_resp(8'h45, 8'h52);
        send_byte(8'h78); send_byte(8'h0D);
        push_resp(8'h45, 8'h52);
        for (int i = 0; i < 7; i++) send_byte(line3[i]);
        push_resp(8'h45, 8'h52);
        wait_idle();
        checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL t3_tx_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; if (o !== e) begin errors++; $display("FAIL t3_tx_byte got %h want %h", o, e); end
        end
        checks++; if (obs_load_q.size() !== 0) begin errors++; $display("FAIL t3_no_load got %0d loads want 0", obs_load_q.size()); end
        checks++; if (Channel_Out !== 4'h2) begin errors++; $display("FAIL t3_chan_hold got %h want 2", Channel_Out); end
        exp_q.delete(); obs_q.delete(); obs_load_q.delete();
    endtask

    task automatic test_empty_line();
        logic [7:0] e, o;
        send_byte(8'h0D); send_byte(8'h0A);
        wait_idle();
        checks++; if (obs_q.size() !== 1) begin errors++; $display("FAIL t4_tx_count got %0d want 1", obs_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; if (o !== e) begin errors++; $display("FAIL t4_tx_byte got %h want %h", o, e); end
        end
        checks++; if (obs_load_q.size() !== 0) begin errors++; $display("FAIL t4_no_load got %0d loads want 0", obs_load_q.size()); end
        exp_q.delete(); obs_q.delete(); obs_load_q.delete();
    endtask

    // Also confirms the parser is back in IDLE after the empty line.
    task automatic test_latency();
        logic [7:0] e, o;
        Channel_In = 4'h3;
        @(negedge Clk_1_410_590);
        Rx_Data = 8'h3F; Rx_Ready = 1'b1;
        @(negedge Clk_1_410_590);
        checks++; if (Rx_Ack !== 1'b1) begin errors++; $display("FAIL lat_rx_ack got %b want 1", Rx_Ack); end
        Rx_Ready = 1'b0;
        @(negedge Clk_1_410_590);
        checks++; if (Tx_Send !== 1'b1) begin errors++; $display("FAIL lat_echo_send got %b want 1", Tx_Send); end
        checks++; if (Rx_Ack !== 1'b0) begin errors++; $display("FAIL lat_rx_ack_fall got %b want 0", Rx_Ack); end
        exp_q.push_back(8'h3F);
        send_byte(8'h0D);
        push_resp(8'h43, 8'h34);
        wait_idle();
        checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL lat_tx_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; if (o !== e) begin errors++; $display("FAIL lat_tx_byte got %h want %h", o, e); end
        end
        exp_q.delete(); obs_q.delete(); obs_load_q.delete();
    endtask

    task automatic test_back_to_back();
        logic [7:0] e, o;
        int n;
        Channel_In = 4'h2;
        send_byte(8'h63); send_byte(8'h31); send_byte(8'h0D);
        push_resp(8'h4F, 8'h4B);
        exp_load_q.push_back(4'h0);
        // Next byte offered while the reply is still going out.
        @(negedge Clk_1_410_590);
        Rx_Data = 8'h3F; Rx_Ready = 1'b1;
        n = 0;
        while (Rx_Ack !== 1'b1 && n < 1000) begin
            @(negedge Clk_1_410_590);
            n++;
        end
        checks++; if (Rx_Ack !== 1'b1) begin errors++; $display("FAIL t5_ack_timeout got %b want 1", Rx_Ack); end
        checks++; if (obs_q.size() !== 7) begin errors++; $display("FAIL t5_ack_early got %0d bytes sent want 7", obs_q.size()); end
        checks++; if (Tx_Busy !== 1'b0) begin errors++; $display("FAIL t5_ack_busy got busy=%b want 0", Tx_Busy); end
        Rx_Ready = 1'b0;
        n = 0;
        while (Rx_Ack !== 1'b0 && n < 100) begin
            @(negedge Clk_1_410_590);
            n++;
        end
        exp_q.push_back(8'h3F);
        send_byte(8'h0D);
        push_resp(8'h43, 8'h33);
        wait_idle();
        checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL t5_tx_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; if (o !== e) begin errors++; $display("FAIL t5_tx_byte got %h want %h", o, e); end
        end
        checks++; if (obs_load_q.size() !== exp_load_q.size()) begin errors++; $display("FAIL t5_load_count got %0d want %0d", obs_load_q.size(), exp_load_q.size()); end
        while (exp_load_q.size() > 0 && obs_load_q.size() > 0) begin
            checks++; o = {4'h0, obs_load_q.pop_front()}; e = {4'h0, exp_load_q.pop_front()};
            if (o !== e) begin errors++; $display("FAIL t5_load_value got %h want %h", o, e); end
        end
        checks++; if (Channel_Out !== 4'h0) begin errors++; $display("FAIL t5_chan_out got %h want 0", Channel_Out); end
        exp_q.delete(); obs_q.delete(); exp_load_q.delete(); obs_load_q.delete();
    endtask

    task automatic test_reset_mid_response();
        logic [7:0] e, o;
        int n;
        Channel_In = 4'h0;
        send_byte(8'h43); send_byte(8'h32); send_byte(8'h0D);
        n = 0;
        while (obs_q.size() < 4 && n < 1000) begin @(negedge Clk_1_410_590); n++; end
        while (Tx_Send !== 1'b0 && n < 1000) begin @(negedge Clk_1_410_590); n++; end
        while (Tx_Send !== 1'b1 && n < 1000) begin @(negedge Clk_1_410_590); n++; end
        checks++; if (n >= 1000) begin errors++; $display("FAIL t6_reach_2nd_byte got %0d bytes want 4", obs_q.size()); end
        checks++; if (Channel_Out !== 4'h1) begin errors++; $display("FAIL t6_pre_reset_chan got %h want 1", Channel_Out); end
        Reset = 1'b1;
        @(negedge Clk_1_410_590);
        checks++; if (Tx_Send !== 1'b0) begin errors++; $display("FAIL t6_reset_tx_send got %b want 0", Tx_Send); end
        checks++; if (Rx_Ack !== 1'b0) begin errors++; $display("FAIL t6_reset_rx_ack got %b want 0", Rx_Ack); end
        checks++; if (Channel_Out !== 4'h0) begin errors++; $display("FAIL t6_reset_chan got %h want 0", Channel_Out); end
        Reset = 1'b0;
        n = 0;
        while ((Tx_Busy !== 1'b0 || n < 5) && n < 200) begin @(negedge Clk_1_410_590); n++; end
        repeat (40) @(negedge Clk_1_410_590);
        checks++; if (obs_q.size() !== 5) begin errors++; $display("FAIL t6_no_resume got %0d bytes want 5", obs_q.size()); end
        checks++; if (obs_q.size() == 5 && obs_q[4] !== 8'h4B) begin errors++; $display("FAIL t6_2nd_byte got %h want 4b", obs_q[4]); end
        exp_q.delete(); obs_q.delete(); obs_load_q.delete();
        send_byte(8'h43); send_byte(8'h32); send_byte(8'h0D);
        push_resp(8'h4F, 8'h4B);
        exp_load_q.push_back(4'h1);
        wait_idle();
        checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL t6_tx_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; if (o !== e) begin errors++; $display("FAIL t6_tx_byte got %h want %h", o, e); end
        end
        checks++; if (obs_load_q.size() !== exp_load_q.size()) begin errors++; $display("FAIL t6_load_count got %0d want %0d", obs_load_q.size(), exp_load_q.size()); end
        while (exp_load_q.size() > 0 && obs_load_q.size() > 0) begin
            checks++; o = {4'h0, obs_load_q.pop_front()}; e = {4'h0, exp_load_q.pop_front()};
            if (o !== e) begin errors++; $display("FAIL t6_load_value got %h want %h", o, e); end
        end
        exp_q.delete(); obs_q.delete(); exp_load_q.delete(); obs_load_q.delete();
    endtask

    task automatic test_protocol();
        checks++;
        if (proto_err !== 0) begin
            errors++;
            $display("FAIL tx_handshake_rules got %0d violations want 0", proto_err);
        end
    endtask

    initial begin
        Reset = 1'b1;
        Rx_Ready = 1'b0;
        Rx_Data = 8'h00;
        Channel_In = 4'h0;
        test_reset();
        test_channel_select();
        test_query();
        test_errors();
        test_empty_line();
        test_latency();
        test_back_to_back();
        test_reset_mid_response();
        test_protocol();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
